// File: rtl/prbs_pkg.sv
// Shared constants and state encoding for the PRBS-23 word checker.
package prbs_pkg;

  // 0-based taps of x^23 + x^18 + 1
  localparam int PRBS23_TAP_A = 22;
  localparam int PRBS23_TAP_B = 17;
  localparam int PRBS_WORD_W  = 12;

  // Checker state encoding; visible on the debug state port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED0 = 3'd1,
    SEED1 = 3'd2,
    SYNC  = 3'd3,
    LOCK  = 3'd4
  } chkState_t;

endpackage

// File: rtl/prbs23_word_checker_step12.sv
// PRBS-23 word predictor: given the last two 12-bit words, produce the next
// 12 bits of the sequence. Purely combinational.
module prbs23_step12
  import prbs_pkg::*;
(
  input  logic [PRBS_WORD_W-1:0] n,
  input  logic [PRBS_WORD_W-1:0] prevN,
  output logic [PRBS_WORD_W-1:0] nextN
);

  logic [2*PRBS_WORD_W-1:0] tmp;

  // Run the serial LFSR recurrence one word's worth of bits over the history.
  always_comb begin
    tmp = {prevN, n};
    for (int i = 0; i < PRBS_WORD_W; i++) begin
      tmp = {tmp[2*PRBS_WORD_W-2:0], tmp[PRBS23_TAP_B] ^ tmp[PRBS23_TAP_A]};
    end
    nextN = tmp[PRBS_WORD_W-1:0];
  end

endmodule

// File: rtl/prbs23_word_checker.sv
// PRBS-23 word checker: seeds from the incoming stream, acquires lock, then
// flywheels through isolated errors while counting mismatches and words.
//
//  state | meaning
//  IDLE  | checker disabled; waits for en
//  SEED0 | next valid word becomes prevW
//  SEED1 | next valid word becomes curW
//  SYNC  | counting consecutive predicted words toward lock
//  LOCK  | locked; mismatches replaced by prediction (flywheel)
module prbs23_word_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERRCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [11:0]         din,
  input  logic                dvalid,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] errCnt,
  output logic [31:0]         wordCnt,
  output logic [2:0]          state
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  chkState_t     curState;
  logic [11:0]   prevW;
  logic [11:0]   curW;
  logic [11:0]   pred;
  logic [GW-1:0] goodCnt;
  logic [BW-1:0] badRun;
  logic          match;
  logic          histLive;
  logic          wordInc;
  logic          errInc;

  prbs23_step12 uStep (
    .n     (curW),
    .prevN (prevW),
    .nextN (pred)
  );

  assign state = curState;

  // Match and counter-increment qualifiers for the current cycle.
  always_comb begin
    match    = (din == pred);
    // An all-zero history predicts zeros forever; refuse to lock on it.
    histLive = |{prevW[10:0], curW};
    wordInc  = en && dvalid && (curState == LOCK);
    errInc   = wordInc && !match;
  end

  // Sequencing FSM with history registers and registered lock/err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= IDLE;
      prevW    <= '0;
      curW     <= '0;
      goodCnt  <= '0;
      badRun   <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!en) begin
        curState <= IDLE;
        locked   <= 1'b0;
        goodCnt  <= '0;
        badRun   <= '0;
      end else begin
        case (curState)
          IDLE: curState <= SEED0;
          SEED0: if (dvalid) begin
            prevW    <= din;
            curState <= SEED1;
          end
          SEED1: if (dvalid) begin
            curW     <= din;
            goodCnt  <= '0;
            curState <= SYNC;
          end
          SYNC: if (dvalid) begin
            prevW <= curW;
            curW  <= din;
            if (match && histLive) begin
              goodCnt <= goodCnt + 1'b1;
              if (goodCnt == GW'(LOCK_COUNT - 1)) begin
                curState <= LOCK;
                locked   <= 1'b1;
                badRun   <= '0;
              end
            end else begin
              goodCnt <= '0;
            end
          end
          LOCK: if (dvalid) begin
            prevW <= curW;
            if (match) begin
              curW   <= din;
              badRun <= '0;
            end else begin
              curW   <= pred;
              err    <= 1'b1;
              badRun <= badRun + 1'b1;
              if (badRun == BW'(UNLOCK_ERRS - 1)) begin
                curState <= SEED0;
                locked   <= 1'b0;
              end
            end
          end
          default: curState <= IDLE;
        endcase
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt  <= '0;
      wordCnt <= '0;
    end else if (clr) begin
      errCnt  <= '0;
      wordCnt <= '0;
    end else begin
      if (errInc && (errCnt != '1)) errCnt <= errCnt + 1'b1;
      if (wordInc && (wordCnt != '1)) wordCnt <= wordCnt + 1'b1;
    end
  end

endmodule
